reg_file_mp: RTL

- Parametrised multi-read-port register file; the next generation of the 14x16 single-port bank.
- Generalised in depth, width and read-port count.
- Adds registered reads with valid flags, out-of-range address detection with a sticky error, and configurable read-during-write behaviour.
- Sits between the datapath and the top-level control block; the bench scoreboard checks against it directly.

---
 rtl/reg_file_pkg.sv | 17 +
 rtl/reg_file_rd_port.sv | 55 +++++
 rtl/reg_file_mp.sv | 84 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants, types and helpers for the multi-read-port register file.
package reg_file_pkg;

    localparam int REG_DEPTH_DEF = 14;
    localparam int REG_WIDTH_DEF = 16;
    localparam int REG_NRD_DEF   = 2;

    typedef logic [15:0] wr_cnt_t;

    // A one-entry file still needs a 1-bit address.
    function automatic int addr_w(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One registered read port: range check, array mux, optional write bypass.
// Write-first bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH_DEF,
    parameter int WIDTH = REG_WIDTH_DEF,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic [AW-1:0]          raddr,
    input  logic [DEPTH*WIDTH-1:0] mem,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   rvalid,
    output logic                   err
);

    logic             in_range;
    logic [WIDTH-1:0] word;

    assign in_range = int'(raddr) < DEPTH;
    assign err      = rd_en && !in_range;

    // Out-of-range addresses fall through the mux and return zero.
    always_comb begin
        word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(raddr) == i) word = mem[i*WIDTH +: WIDTH];
        end
`ifdef REG_FILE_BYPASS_EN
        if (we && in_range && (waddr == raddr)) word = wdata;
`endif
    end

`ifndef REG_FILE_BYPASS_EN
    logic unused_bypass;
    assign unused_bypass = ^{we, waddr, wdata};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) rdata <= word;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file with NRD registered read ports, sticky address
// error and saturating write counter. Optional macro: REG_FILE_BYPASS_EN.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DEPTH = REG_DEPTH_DEF,
    parameter int WIDTH = REG_WIDTH_DEF,
    parameter int NRD   = REG_NRD_DEF,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rvalid,
    output logic                 addr_err,
    input  logic                 err_clr,
    output logic [15:0]          wr_count
);

    logic [DEPTH*WIDTH-1:0] mem;
    logic [NRD-1:0]         rd_err;
    logic                   wr_ok;
    logic                   wr_err;
    wr_cnt_t                wr_cnt_q;

    assign wr_ok    = we && (int'(waddr) < DEPTH);
    assign wr_err   = we && !(int'(waddr) < DEPTH);
    assign wr_count = wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (int'(waddr) == i) mem[i*WIDTH +: WIDTH] <= wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
        end else if (wr_ok && (wr_cnt_q != 16'hFFFF)) begin
            wr_cnt_q <= wr_cnt_q + 16'd1;
        end
    end

    // A new error on the same edge as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_err <= 1'b0;
        end else if (wr_err || (|rd_err)) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_port
        reg_file_rd_port #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .AW    (AW)
        ) u_port (
            .clk    (clk),
            .rst_n  (rst_n),
            .rd_en  (rd_en[k]),
            .raddr  (raddr[k*AW +: AW]),
            .mem    (mem),
            .we     (we),
            .waddr  (waddr),
            .wdata  (wdata),
            .rdata  (rdata[k*WIDTH +: WIDTH]),
            .rvalid (rvalid[k]),
            .err    (rd_err[k])
        );
    end

endmodule
